// File: rtl/aver_filter_3x3.sv
// 3x3 mean (box) filter stage for one colour channel.
// Consumes the window from the line-buffer matrix stage and emits floor(sum/9)
// for interior pixels and the centre pixel for border pixels or in bypass.
// Data and hs/vs/de share a fixed 4-cycle latency.
// Build option: define AVER_ROUND_EN to round to nearest instead of flooring.
module aver_filter_3x3 #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned V_ACTIVE = 1080
) (
  input  logic       video_clk,
  input  logic       rst,
  input  logic       filter_en,
  input  logic       video_hs,
  input  logic       video_vs,
  input  logic       video_de,
  input  logic [7:0] matrix11,
  input  logic [7:0] matrix12,
  input  logic [7:0] matrix13,
  input  logic [7:0] matrix21,
  input  logic [7:0] matrix22,
  input  logic [7:0] matrix23,
  input  logic [7:0] matrix31,
  input  logic [7:0] matrix32,
  input  logic [7:0] matrix33,
  output logic       filt_hs,
  output logic       filt_vs,
  output logic       filt_de,
  output logic [7:0] filt_data
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned RW = 10;
  localparam int unsigned SW = 12;
  localparam int unsigned PW = 25;
  localparam int unsigned DW = 8;
  localparam int unsigned PD = 3;
  // ceil(65536/9): multiply-and-shift gives an exact divide-by-9 over the sum range
  localparam logic [PW-1:0] RECIP = PW'(7282);

  logic          de_d;
  logic          vs_d;
  logic          frame_en;
  logic          synced;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  logic          vs_rise_c;
  logic          de_fall_c;
  logic          border_c;
  logic          bypass_c;

  logic [RW-1:0] r1;
  logic [RW-1:0] r2;
  logic [RW-1:0] r3;
  logic [SW-1:0] sum;
  logic [PW-1:0] prod;

  logic [PD-1:0] hs_s;
  logic [PD-1:0] vs_s;
  logic [PD-1:0] de_s;
  logic [PD-1:0] byp_s;
  logic [DW-1:0] m22_s [PD];

  // Edge detection and per-pixel border / bypass decision on the input side
  always_comb begin
    vs_rise_c = video_vs && !vs_d;
    de_fall_c = de_d && !video_de;
    border_c  = !synced
             || (x_cnt == '0) || (x_cnt == XW'(H_ACTIVE - 1))
             || (y_cnt == '0) || (y_cnt == YW'(V_ACTIVE - 1));
    bypass_c  = border_c || !frame_en;
  end

  // Pixel/line position counters and frame-level filter enable
  always_ff @(posedge video_clk) begin
    if (rst) begin
      de_d     <= 1'b0;
      vs_d     <= 1'b0;
      frame_en <= 1'b1;
      synced   <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else begin
      de_d <= video_de;
      vs_d <= video_vs;
      if (vs_rise_c) begin
        frame_en <= filter_en;
        synced   <= 1'b1;
      end
      // over-long lines hold at the last column until de falls
      if (de_fall_c) begin
        x_cnt <= '0;
      end else if (video_de && (x_cnt != XW'(H_ACTIVE - 1))) begin
        x_cnt <= x_cnt + XW'(1);
      end
      // vs rise takes priority over a coincident de fall
      if (vs_rise_c) begin
        y_cnt <= '0;
      end else if (de_fall_c) begin
        y_cnt <= y_cnt + YW'(1);
      end
    end
  end

  // Arithmetic pipeline: row sums, window sum, reciprocal multiply, output select
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      sum       <= '0;
      prod      <= '0;
      filt_data <= '0;
    end else begin
      r1   <= RW'(matrix11) + RW'(matrix12) + RW'(matrix13);
      r2   <= RW'(matrix21) + RW'(matrix22) + RW'(matrix23);
      r3   <= RW'(matrix31) + RW'(matrix32) + RW'(matrix33);
`ifdef AVER_ROUND_EN
      sum  <= SW'(r1) + SW'(r2) + SW'(r3) + SW'(4);
`else
      sum  <= SW'(r1) + SW'(r2) + SW'(r3);
`endif
      prod <= PW'(sum) * RECIP;
      filt_data <= de_s[PD-1] ? (byp_s[PD-1] ? m22_s[PD-1] : DW'(prod >> 16)) : '0;
    end
  end

  // Sync, bypass flag and centre pixel delay lines matched to the arithmetic
  always_ff @(posedge video_clk) begin
    if (rst) begin
      hs_s    <= '0;
      vs_s    <= '0;
      de_s    <= '0;
      byp_s   <= '0;
      filt_hs <= 1'b0;
      filt_vs <= 1'b0;
      filt_de <= 1'b0;
      for (int i = 0; i < PD; i++) begin
        m22_s[i] <= '0;
      end
    end else begin
      hs_s    <= {hs_s[PD-2:0], video_hs};
      vs_s    <= {vs_s[PD-2:0], video_vs};
      de_s    <= {de_s[PD-2:0], video_de};
      byp_s   <= {byp_s[PD-2:0], bypass_c};
      filt_hs <= hs_s[PD-1];
      filt_vs <= vs_s[PD-1];
      filt_de <= de_s[PD-1];
      m22_s[0] <= matrix22;
      for (int i = 1; i < PD; i++) begin
        m22_s[i] <= m22_s[i-1];
      end
    end
  end

endmodule
